staged_counter: RTL and testbench

Parametrised chain of saturating counters that fire one after another. Stage 0 counts from 0 up to its limit and holds. Stage 1 then counts up to its limit, and so on through the last stage. When every stage sits at its limit, the next enabled cycle returns the whole chain to zero. It is the generalised successor of the two-stage fixed counter and is used as a sequencer and phase generator in the design. Stage count, width, per-stage limits, enable, clear, and status outputs are all configurable.

---
 rtl/staged_counter.sv | 106 ++++++++++
 tb/tb_staged_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/staged_counter.sv
// staged_counter: chain of saturating counters that fire one after another.
// Stage 0 counts up to its limit and holds, then stage 1 counts, and so on.
// Once every stage sits at its limit, the next enabled cycle returns the
// whole chain to zero and pulses _o_wrap.
// Optional build macro STAGED_COUNTER_ONESHOT_EN: the chain halts in the
// all-at-limit state until it is cleared or reset, and never wraps.
module staged_counter #(
  parameter int                          NUM_STAGES = 2,
  parameter int                          WIDTH      = 8,
  parameter logic [NUM_STAGES*WIDTH-1:0] LIMITS     = {8'd8, 8'd6}
) (
  input  logic                          _i_clk,
  input  logic                          _i_rst,
  input  logic                          _i_en,
  input  logic                          _i_clear,
  output logic [NUM_STAGES*WIDTH-1:0]   __output,
  output logic                          _o_done,
  output logic                          _o_wrap
);

  // Each limit occupies exactly WIDTH bits of LIMITS, so it always fits a
  // stage; only the chain dimensions themselves need guarding.
  if (NUM_STAGES < 1 || WIDTH < 1) begin : g_bad_params
    $error("staged_counter: NUM_STAGES and WIDTH must both be >= 1");
  end

  logic [WIDTH-1:0]      cnt_q [NUM_STAGES];
  logic [WIDTH-1:0]      cnt_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] at_lim;
  logic [NUM_STAGES-1:0] inc;
  logic                  all_lim;
  logic                  wrap_q;
  logic                  wrap_d;

  // Locate the single active stage: first stage not yet at its limit.
  always_comb begin
    logic prefix;
    // NOTE: every combinational output gets a default before any branch or
    // loop writes it, so no path can leave it unassigned and infer a latch.
    at_lim = '0;
    inc    = '0;
    prefix = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      at_lim[i] = (cnt_q[i] == LIMITS[(NUM_STAGES-1-i)*WIDTH +: WIDTH]);
      inc[i]    = prefix & ~at_lim[i];
      prefix    = prefix & at_lim[i];
    end
    all_lim = prefix;
  end

  // Next-state: advance the active stage, or wrap from the all-at-limit state.
  always_comb begin
    wrap_d = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      cnt_d[i] = cnt_q[i];
    end
`ifdef STAGED_COUNTER_ONESHOT_EN
    // Halted at the top: enable is ignored until clear or reset.
    if (_i_en && !all_lim) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (inc[i]) cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
    end
`else
    if (_i_en && all_lim) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_d[i] = '0;
      end
      wrap_d = 1'b1;
    end else if (_i_en) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (inc[i]) cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
    end
`endif
  end

  // State registers: synchronous reset, then clear, then normal update.
  always_ff @(posedge _i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!_i_rst || _i_clear) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_q[i] <= '0;
      end
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wrap_q <= wrap_d;
    end
  end

  // Pack stage values with stage 0 in the most significant field.
  always_comb begin
    __output = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      __output[(NUM_STAGES-1-i)*WIDTH +: WIDTH] = cnt_q[i];
    end
  end

  assign _o_done = all_lim;
  assign _o_wrap = wrap_q;

endmodule

// File: tb/tb_staged_counter.sv
// Directed bench for staged_counter. Four instances cover the default chain,
// a chain with a zero-limit middle stage, a 4-bit width corner and an
// all-zero-limit single stage. Expectations follow STAGED_COUNTER_ONESHOT_EN
// when the bench is compiled with that macro.
module tb_staged_counter;

  logic clk;
  int   n_cmp = 0;
  int   n_err = 0;

  // Default chain: 2 stages, 8 bits, limits {8,6}.
  logic        rst_a, en_a, clr_a;
  logic [15:0] out_a;
  logic        done_a, wrap_a;
  // Zero-limit middle stage: limits {3,0,2}.
  logic        rst_b, en_b, clr_b;
  logic [23:0] out_b;
  logic        done_b, wrap_b;
  // Width corner: 4 bits, limits {15,15}.
  logic        rst_c, en_c, clr_c;
  logic [7:0]  out_c;
  logic        done_c, wrap_c;
  // Single stage with limit 0.
  logic        rst_d, en_d, clr_d;
  logic [3:0]  out_d;
  logic        done_d, wrap_d;

  staged_counter u_a (
    ._i_clk(clk), ._i_rst(rst_a), ._i_en(en_a), ._i_clear(clr_a),
    .__output(out_a), ._o_done(done_a), ._o_wrap(wrap_a)
  );

  staged_counter #(.NUM_STAGES(3), .WIDTH(8), .LIMITS(24'h03_00_02)) u_b (
    ._i_clk(clk), ._i_rst(rst_b), ._i_en(en_b), ._i_clear(clr_b),
    .__output(out_b), ._o_done(done_b), ._o_wrap(wrap_b)
  );

  staged_counter #(.NUM_STAGES(2), .WIDTH(4), .LIMITS(8'hFF)) u_c (
    ._i_clk(clk), ._i_rst(rst_c), ._i_en(en_c), ._i_clear(clr_c),
    .__output(out_c), ._o_done(done_c), ._o_wrap(wrap_c)
  );

  staged_counter #(.NUM_STAGES(1), .WIDTH(4), .LIMITS(4'h0)) u_d (
    ._i_clk(clk), ._i_rst(rst_d), ._i_en(en_d), ._i_clear(clr_d),
    .__output(out_d), ._o_done(done_d), ._o_wrap(wrap_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected default-chain value after n enabled increments (n <= 14).
  function automatic logic [15:0] exp_def(input int n);
    int s0, s1;
    s0 = (n > 8) ? 8 : n;
    s1 = (n > 8) ? n - 8 : 0;
    return {8'(s0), 8'(s1)};
  endfunction

  int          n_en;
  logic        wrap_seen;
  logic [23:0] seq_b [6];

  initial begin
    {rst_a, rst_b, rst_c, rst_d} = '0;
    {clr_a, clr_b, clr_c, clr_d} = '0;
    {en_b, en_c, en_d}           = '0;
    en_a = 1'b1;

    // ---------------- Reset and basic sequence (default chain) ----------
    step(); step();
    check("rst_out",  32'(out_a),  32'h0000);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_wrap", 32'(wrap_a), 32'h0);
    {rst_a, rst_b, rst_c, rst_d} = 4'hF;
    check("release_out", 32'(out_a), 32'h0000);
    for (int i = 0; i < 8; i++) step();
    check("edge8_out",  32'(out_a),  32'h0800);
    check("edge8_done", 32'(done_a), 32'h0);
    for (int i = 0; i < 6; i++) step();
    check("edge14_out",  32'(out_a),  32'h0806);
    check("edge14_done", 32'(done_a), 32'h1);
    step();
`ifdef STAGED_COUNTER_ONESHOT_EN
    check("oneshot_hold_out",  32'(out_a),  32'h0806);
    check("oneshot_hold_wrap", 32'(wrap_a), 32'h0);
    wrap_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      wrap_seen = wrap_seen | wrap_a;
    end
    check("oneshot_40_out",  32'(out_a),     32'h0806);
    check("oneshot_40_done", 32'(done_a),    32'h1);
    check("oneshot_40_wrap", 32'(wrap_seen), 32'h0);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("oneshot_clr_out", 32'(out_a), 32'h0000);
    step();
    check("oneshot_resume", 32'(out_a), 32'h0100);
`else
    check("wrap1_out",  32'(out_a),  32'h0000);
    check("wrap1_wrap", 32'(wrap_a), 32'h1);
    check("wrap1_done", 32'(done_a), 32'h0);
    step();
    check("post_wrap_out",  32'(out_a),  32'h0100);
    check("post_wrap_wrap", 32'(wrap_a), 32'h0);
    for (int i = 0; i < 13; i++) step();
    check("period_top", 32'(out_a), 32'h0806);
    step();
    check("wrap2_out",  32'(out_a),  32'h0000);
    check("wrap2_wrap", 32'(wrap_a), 32'h1);
`endif

    // ---------------- Enable gaps ----------------------------------------
    rst_a = 1'b0; en_a = 1'b0;
    step();
    rst_a = 1'b1;
    n_en  = 0;
    for (int k = 1; k <= 28; k++) begin
      en_a = (k % 2 == 0);
      step();
      if (en_a) n_en++;
      check($sformatf("gap_edge%0d", k), 32'(out_a), 32'(exp_def(n_en)));
    end
    check("gap_done28", 32'(done_a), 32'h1);
    en_a = 1'b0;

    // ---------------- Clear mid-run, then reset together with clear -----
    rst_a = 1'b0;
    step();
    rst_a = 1'b1; en_a = 1'b1;
    for (int i = 0; i < 11; i++) step();
    check("pre_clr_out", 32'(out_a), 32'h0803);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("clr_out",  32'(out_a),  32'h0000);
    check("clr_wrap", 32'(wrap_a), 32'h0);
    step();
    check("clr_resume", 32'(out_a), 32'h0100);
    for (int i = 0; i < 10; i++) step();
    check("pre_rstclr_out", 32'(out_a), 32'h0803);
    rst_a = 1'b0; clr_a = 1'b1;
    step();
    rst_a = 1'b1; clr_a = 1'b0;
    check("rstclr_out",  32'(out_a),  32'h0000);
    check("rstclr_wrap", 32'(wrap_a), 32'h0);
    step();
    check("rstclr_resume", 32'(out_a), 32'h0100);
    en_a = 1'b0;

    // ---------------- Zero-limit middle stage ----------------------------
    check("zl_rst_out",  32'(out_b),  32'h000000);
    check("zl_rst_done", 32'(done_b), 32'h0);
    seq_b[0] = 24'h010000;
    seq_b[1] = 24'h020000;
    seq_b[2] = 24'h030000;
    seq_b[3] = 24'h030001;
    seq_b[4] = 24'h030002;
`ifdef STAGED_COUNTER_ONESHOT_EN
    seq_b[5] = 24'h030002;
`else
    seq_b[5] = 24'h000000;
`endif
    en_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("zl_edge%0d", i + 1), 32'(out_b), 32'(seq_b[i]));
      if (i == 4) check("zl_done", 32'(done_b), 32'h1);
    end
`ifdef STAGED_COUNTER_ONESHOT_EN
    check("zl_wrap", 32'(wrap_b), 32'h0);
`else
    check("zl_wrap", 32'(wrap_b), 32'h1);
`endif
    en_b = 1'b0;

    // ---------------- Width corner: 4 bits, limits {15,15} --------------
    en_c = 1'b1;
    for (int i = 0; i < 29; i++) step();
    check("w_edge29_out",  32'(out_c),  32'h0FE);
    check("w_edge29_done", 32'(done_c), 32'h0);
    step();
    check("w_edge30_out",  32'(out_c),  32'h0FF);
    check("w_edge30_done", 32'(done_c), 32'h1);
    step();
`ifdef STAGED_COUNTER_ONESHOT_EN
    check("w_edge31_out",  32'(out_c),  32'h0FF);
    check("w_edge31_wrap", 32'(wrap_c), 32'h0);
`else
    check("w_edge31_out",  32'(out_c),  32'h000);
    check("w_edge31_wrap", 32'(wrap_c), 32'h1);
`endif
    en_c = 1'b0;

    // ---------------- All limits zero ------------------------------------
    check("z0_rst_done", 32'(done_d), 32'h1);
    check("z0_rst_wrap", 32'(wrap_d), 32'h0);
    en_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("z0_out%0d", i), 32'(out_d),  32'h0);
      check($sformatf("z0_done%0d", i), 32'(done_d), 32'h1);
`ifdef STAGED_COUNTER_ONESHOT_EN
      check($sformatf("z0_wrap%0d", i), 32'(wrap_d), 32'h0);
`else
      check($sformatf("z0_wrap%0d", i), 32'(wrap_d), 32'h1);
`endif
    end
    en_d = 1'b0;
    step();
    check("z0_idle_wrap", 32'(wrap_d), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
